// File: rtl/crc_tx_pkg.sv
// USB CRC-16 TX constants and state type; shared by the generator and its LFSR.
// No timing of its own; no flow control.
package crc_tx_pkg;

    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_DATA = 2'd1,
        TX_CRC  = 2'd2
    } crc_tx_state_t;

endpackage

// File: rtl/crc16_lfsr.sv
// Serial CRC-16 register: preset, or on enable either absorb din through POLY or shift in a 1.
// Latency 1 cycle from enable to updated remainder; no backpressure, the enable is the strobe.
module crc16_lfsr
    import crc_tx_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] INIT = CRC16_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        preset,
    input  logic        en,
    input  logic        absorb,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_d;
    logic [15:0] crc_q;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = din ^ crc_q[15];
        if (preset) begin
            crc_d = INIT;
        end else if (en) begin
            if (absorb) begin
                crc_d = {crc_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
            end else begin
                // Shifting in ones drains the remainder and leaves it back at all-ones.
                crc_d = {crc_q[14:0], 1'b1};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_gen_16bit_tx.sv
// USB TX CRC-16: absorbs payload bits on valid strobes, then serializes ~remainder MSB first; remainder updates 1 cycle after strobe.
// No backpressure (strobe-paced, stuff strobes skipped); CRC_TX_SELFCHECK_EN adds a shadow residue check on crc_err.
module crc_gen_16bit_tx
    import crc_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        shift_enable,
    input  logic        bit_stuff_st,
    input  logic        data_bit,
    input  logic        data_done,
    output logic        serial_out,
    output logic        crc_active,
    output logic        crc_done,
    output logic [15:0] crc_value
`ifdef CRC_TX_SELFCHECK_EN
    ,
    output logic        crc_err
`endif
);

    crc_tx_state_t state_d, state_q;
    logic [3:0]    bit_cnt_d, bit_cnt_q;
    logic          vs;
    logic          in_pkt;
    logic          last_bit;
    logic          lfsr_en;

    assign vs       = shift_enable & ~bit_stuff_st;
    assign in_pkt   = (state_q == TX_DATA) || (state_q == TX_CRC);
    assign last_bit = (state_q == TX_CRC) && vs && (bit_cnt_q == 4'd15);
    // A start on the same strobe presets instead of absorbing the bit.
    assign lfsr_en  = vs && in_pkt && !start;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (start) begin
            state_d   = TX_DATA;
            bit_cnt_d = 4'd0;
        end else begin
            case (state_q)
                TX_DATA: begin
                    if (data_done) begin
                        state_d = TX_CRC;
                    end
                end
                TX_CRC: begin
                    if (vs) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            state_d   = TX_IDLE;
                            bit_cnt_d = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            bit_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    crc16_lfsr #(
        .POLY (CRC16_POLY),
        .INIT (CRC16_INIT)
    ) u_crc (
        .clk    (clk),
        .rst    (rst),
        .preset (start),
        .en     (lfsr_en),
        .absorb (state_q == TX_DATA),
        .din    (data_bit),
        .crc    (crc_value)
    );

    assign serial_out = (state_q == TX_CRC) ? ~crc_value[15] : data_bit;
    assign crc_active = (state_q == TX_CRC);
    assign crc_done   = last_bit && !start;

`ifdef CRC_TX_SELFCHECK_EN
    logic [15:0] shadow_crc;
    logic        done_d, done_q;

    // Shadow sees the wire, CRC included, so a clean packet lands on the fixed residue.
    crc16_lfsr #(
        .POLY (CRC16_POLY),
        .INIT (CRC16_INIT)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .preset (start),
        .en     (lfsr_en),
        .absorb (1'b1),
        .din    (serial_out),
        .crc    (shadow_crc)
    );

    always_comb begin
        done_d = crc_done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign crc_err = done_q && (shadow_crc != CRC16_RESIDUE);
`endif

endmodule

// File: tb/tb_crc_gen_16bit_tx.sv
// Randomized and directed stimulus against a polynomial long-division model; a negedge monitor drains the expected-bit scoreboard.
module tb_crc_gen_16bit_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        shift_enable = 1'b0;
    logic        bit_stuff_st = 1'b0;
    logic        data_bit = 1'b0;
    logic        data_done = 1'b0;
    logic        serial_out;
    logic        crc_active;
    logic        crc_done;
    logic [15:0] crc_value;
`ifdef CRC_TX_SELFCHECK_EN
    logic        crc_err;
`endif

    int errors = 0;
    int checks = 0;
    bit sb_en  = 1'b0;

    logic [15:0] rem_q[$];
    logic [1:0]  bit_q[$];   // {expected crc_done, expected serial_out}

    crc_gen_16bit_tx dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .shift_enable (shift_enable),
        .bit_stuff_st (bit_stuff_st),
        .data_bit     (data_bit),
        .data_done    (data_done),
        .serial_out   (serial_out),
        .crc_active   (crc_active),
        .crc_done     (crc_done),
        .crc_value    (crc_value)
`ifdef CRC_TX_SELFCHECK_EN
        ,
        .crc_err      (crc_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Remainder of (M(x)*x^16 + INIT*x^n) mod G(x) by textbook long division.
    function automatic logic [15:0] crc_model(input int n, input logic [31:0] bits);
        bit          seq[0:47];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h18005;
        for (int i = 0; i < 48; i++) seq[i] = 1'b0;
        for (int i = 0; i < n; i++) seq[i] = bits[i];
        for (int i = 0; i < 16; i++) seq[i] = ~seq[i];
        for (int i = 0; i < n; i++) begin
            if (seq[i]) begin
                for (int j = 0; j <= 16; j++) seq[i+j] = seq[i+j] ^ g[16-j];
            end
        end
        for (int k = 0; k < 16; k++) r[15-k] = seq[n+k];
        return r;
    endfunction

    task automatic cyc(input logic se, input logic st, input logic db, input logic dd, input logic s);
        @(posedge clk);
        #1;
        shift_enable = se;
        bit_stuff_st = st;
        data_bit     = db;
        data_done    = dd;
        start        = s;
    endtask

    task automatic send_pkt(input int len, input logic [31:0] bits, input int crc_stuff,
                            input bit rnd, input bit use_lit, input logic [15:0] lit);
        logic [15:0] rem;
        bit          together;
        int          stuff_left;
        rem = crc_model(len, bits);
        rem_q.push_back(rem);
        for (int k = 0; k < 16; k++) bit_q.push_back({(k == 15), ~rem[15-k]});
        together   = rnd && ($urandom_range(0, 1) == 1);
        stuff_left = crc_stuff;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < len; i++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
                if ($urandom_range(0, 3) == 0) cyc(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
            end
            cyc(1'b1, 1'b0, bits[i], (together && i == len - 1), 1'b0);
        end
        if (!together || len == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (use_lit) begin
            @(negedge clk);
            chk("remainder_literal", crc_value, lit);
        end
        for (int k = 0; k < 16; k++) begin
            if (rnd) begin
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
                if ($urandom_range(0, 4) == 0) cyc(1'b1, 1'b1, 1'($urandom), 1'b0, 1'b0);
            end
            if (stuff_left > 0 && (k % 4) == 1) begin
                cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                stuff_left--;
            end
            cyc(1'b1, 1'b0, 1'($urandom), 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("post_done_crc_value", crc_value, 16'hFFFF);
        chk("post_done_active", {15'd0, crc_active}, 16'd0);
    endtask

    // Monitor: compares every non-stuffed CRC strobe against the scoreboard.
    bit prev_active = 1'b0;
    bit prev_done   = 1'b0;
    always @(negedge clk) begin
        logic [1:0] e;
        if (sb_en && !rst) begin
            if (crc_active && !prev_active) begin
                if (rem_q.size() == 0) chk("rem_queue_underflow", 16'd1, 16'd0);
                else chk("remainder", crc_value, rem_q.pop_front());
            end
            if (crc_active && shift_enable && !bit_stuff_st) begin
                if (bit_q.size() == 0) begin
                    chk("bit_queue_underflow", 16'd1, 16'd0);
                end else begin
                    e = bit_q.pop_front();
                    chk("serial_out", {15'd0, serial_out}, {15'd0, e[0]});
                    chk("crc_done", {15'd0, crc_done}, {15'd0, e[1]});
                end
            end else if (crc_done) begin
                chk("spurious_crc_done", 16'd1, 16'd0);
            end
`ifdef CRC_TX_SELFCHECK_EN
            if (prev_done) chk("crc_err", {15'd0, crc_err}, 16'd0);
`endif
        end
        prev_active = crc_active;
        prev_done   = crc_done && sb_en;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        chk("reset_crc_value", crc_value, 16'hFFFF);
        chk("reset_active", {15'd0, crc_active}, 16'd0);
        chk("reset_done", {15'd0, crc_done}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("idle_passthrough", {15'd0, serial_out}, 16'd1);

        sb_en = 1'b1;
        send_pkt(0, 32'h0, 0, 1'b0, 1'b1, 16'hFFFF);   // empty payload: all-zero CRC stream
        send_pkt(1, 32'h1, 0, 1'b0, 1'b1, 16'hFFFE);   // single '1'
        send_pkt(1, 32'h0, 0, 1'b0, 1'b1, 16'h7FFB);   // single '0'
        send_pkt(1, 32'h0, 3, 1'b0, 1'b1, 16'h7FFB);   // single '0', 3 stuffed CRC strobes
        send_pkt(16, 32'hFFFF, 0, 1'b0, 1'b0, 16'h0);
        for (int p = 0; p < 30; p++) begin
            send_pkt(int'($urandom_range(0, 24)), $urandom, 0, 1'b1, 1'b0, 16'h0);
        end

        // Reset asserted while the 6th CRC bit is on the line.
        sb_en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst          = 1'b1;
        shift_enable = 1'b1;
        @(negedge clk);
        chk("midcrc_rst_value", crc_value, 16'hFFFF);
        chk("midcrc_rst_active", {15'd0, crc_active}, 16'd0);
        chk("midcrc_rst_done", {15'd0, crc_done}, 16'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        shift_enable = 1'b0;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("after_rst_idle", {14'd0, crc_active, crc_done}, 16'd0);
        chk("after_rst_value", crc_value, 16'hFFFF);

        sb_en = 1'b1;
        send_pkt(8, 32'hA5, 0, 1'b1, 1'b0, 16'h0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 16'(rem_q.size() + bit_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
